// File: rtl/pipe_ctrl_if.sv
// Control-unit handshake bundle: ID-stage decode inputs, datapath feedback,
// and the staged control outputs that drive the 5-stage datapath.
interface pipe_ctrl_if #(
  parameter int unsigned RW = 5
);
  logic          id_valid;
  logic [4:0]    id_opcode;
  logic [4:0]    id_aluop;
  logic [RW-1:0] id_rd;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic          ex_taken;
  logic          md_ready;

  logic          stall;
  logic          flush;
  logic [4:0]    ex_alu_opcode;
  logic          ex_aluinb;
  logic          ex_bne;
  logic          ex_blt;
  logic          ex_bex;
  logic          ex_jp;
  logic          ex_jr;
  logic          md_start;
  logic [1:0]    fwd_a;
  logic [1:0]    fwd_b;
  logic          mem_dmwe;
  logic          mem_rwd;
  logic          wb_rwe;
  logic [RW-1:0] wb_rd;
  logic [1:0]    wb_sel;

  modport master (
    output id_valid, id_opcode, id_aluop, id_rd, id_rs, id_rt, ex_taken, md_ready,
    input  stall, flush, ex_alu_opcode, ex_aluinb, ex_bne, ex_blt, ex_bex, ex_jp,
           ex_jr, md_start, fwd_a, fwd_b, mem_dmwe, mem_rwd, wb_rwe, wb_rd, wb_sel
  );

  modport slave (
    input  id_valid, id_opcode, id_aluop, id_rd, id_rs, id_rt, ex_taken, md_ready,
    output stall, flush, ex_alu_opcode, ex_aluinb, ex_bne, ex_blt, ex_bex, ex_jp,
           ex_jr, md_start, fwd_a, fwd_b, mem_dmwe, mem_rwd, wb_rwe, wb_rd, wb_sel
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipelined control unit: ID decode, ID/EX/MEM/WB control staging, hazard
// stalls, forwarding selects, branch flush and the mult/div start/ready FSM.
// Build option: define FORWARD_EN to enable MEM/WB forwarding (only load-use
// and mult/div stall); without it every RAW hazard stalls until the writer
// has left WB and the forwarding selects stay 00.
module pipe_ctrl #(
  parameter int unsigned RW         = 5,
  parameter int unsigned LINK_REG   = 31,
  parameter int unsigned STATUS_REG = 30
) (
  input logic        clock,
  input logic        reset,
  pipe_ctrl_if.slave bus
);

  localparam int unsigned OPW = 5;

  localparam logic [OPW-1:0] OP_ADD  = 5'b00000;
  localparam logic [OPW-1:0] OP_J    = 5'b00001;
  localparam logic [OPW-1:0] OP_BNE  = 5'b00010;
  localparam logic [OPW-1:0] OP_JAL  = 5'b00011;
  localparam logic [OPW-1:0] OP_JR   = 5'b00100;
  localparam logic [OPW-1:0] OP_ADDI = 5'b00101;
  localparam logic [OPW-1:0] OP_BLT  = 5'b00110;
  localparam logic [OPW-1:0] OP_SW   = 5'b00111;
  localparam logic [OPW-1:0] OP_LW   = 5'b01000;
  localparam logic [OPW-1:0] OP_SETX = 5'b10101;
  localparam logic [OPW-1:0] OP_BEX  = 5'b10110;

  localparam logic [OPW-1:0] ALU_ADD = 5'b00000;
  localparam logic [OPW-1:0] ALU_SUB = 5'b00001;
  localparam logic [OPW-1:0] ALU_MUL = 5'b00110;
  localparam logic [OPW-1:0] ALU_DIV = 5'b00111;

  typedef struct packed {
    logic [OPW-1:0] alu_op;
    logic           aluinb;
    logic           bne;
    logic           blt;
    logic           bex;
    logic           jp;
    logic           jr;
    logic           md;
    logic           dmwe;
    logic           rwd;
    logic           rwe;
    logic [1:0]     sel;
    logic [RW-1:0]  rd;
  } ctrl_t;

  typedef struct packed {
    logic          dmwe;
    logic          rwd;
    logic          rwe;
    logic [1:0]    sel;
    logic [RW-1:0] rd;
  } mem_t;

  typedef struct packed {
    logic          rwe;
    logic [1:0]    sel;
    logic [RW-1:0] rd;
  } wb_t;

  typedef enum logic {S_IDLE, S_WAIT} md_state_t;

  // True when a stage with a live register write targets a nonzero source.
  function automatic logic hit(input logic [RW-1:0] src, input logic v,
                               input logic rwe, input logic [RW-1:0] dst);
    return v && rwe && (src != '0) && (src == dst);
  endfunction

  ctrl_t         id_c;
  logic          id_ok;
  logic [RW-1:0] id_src_a;
  logic [RW-1:0] id_src_b;

  logic          ex_v;
  ctrl_t         ex_c;
  logic          mem_v;
  mem_t          mem_c;
  logic          wb_v;
  wb_t           wb_c;
  md_state_t     state;
  md_state_t     state_nx;

  logic          raw_c;
  logic          flush_c;
  logic          md_busy_c;
  logic          ex_load_c;

`ifdef FORWARD_EN
  logic [RW-1:0] ex_src_a;
  logic [RW-1:0] ex_src_b;
`endif

  // ID decode: control word, source registers and destination.
  always_comb begin
    id_c     = '0;
    id_ok    = 1'b0;
    id_src_a = '0;
    id_src_b = '0;
    if (bus.id_valid) begin
      id_ok = 1'b1;
      case (bus.id_opcode)
        OP_ADD: begin
          id_c.alu_op = bus.id_aluop;
          id_c.md     = (bus.id_aluop == ALU_MUL) || (bus.id_aluop == ALU_DIV);
          id_c.rwe    = 1'b1;
          id_c.rd     = bus.id_rd;
          id_src_a    = bus.id_rs;
          id_src_b    = bus.id_rt;
        end
        OP_J:    id_c.jp = 1'b1;
        OP_BNE: begin
          id_c.bne    = 1'b1;
          id_c.alu_op = ALU_SUB;
          id_src_a    = bus.id_rd;
          id_src_b    = bus.id_rs;
        end
        OP_JAL: begin
          id_c.jp  = 1'b1;
          id_c.rwe = 1'b1;
          id_c.rd  = RW'(LINK_REG);
          id_c.sel = 2'b10;
        end
        OP_JR: begin
          id_c.jr  = 1'b1;
          id_src_a = bus.id_rd;
        end
        OP_ADDI: begin
          id_c.alu_op = ALU_ADD;
          id_c.aluinb = 1'b1;
          id_c.rwe    = 1'b1;
          id_c.rd     = bus.id_rd;
          id_src_a    = bus.id_rs;
        end
        OP_BLT: begin
          id_c.blt    = 1'b1;
          id_c.alu_op = ALU_SUB;
          id_src_a    = bus.id_rd;
          id_src_b    = bus.id_rs;
        end
        OP_SW: begin
          id_c.alu_op = ALU_ADD;
          id_c.aluinb = 1'b1;
          id_c.dmwe   = 1'b1;
          id_src_a    = bus.id_rs;
          id_src_b    = bus.id_rd;
        end
        OP_LW: begin
          id_c.alu_op = ALU_ADD;
          id_c.aluinb = 1'b1;
          id_c.rwd    = 1'b1;
          id_c.rwe    = 1'b1;
          id_c.rd     = bus.id_rd;
          id_c.sel    = 2'b01;
          id_src_a    = bus.id_rs;
        end
        OP_SETX: begin
          id_c.rwe = 1'b1;
          id_c.rd  = RW'(STATUS_REG);
          id_c.sel = 2'b11;
        end
        OP_BEX: begin
          id_c.bex    = 1'b1;
          id_c.alu_op = ALU_SUB;
          id_src_a    = RW'(STATUS_REG);
        end
        default: id_ok = 1'b0;
      endcase
      if (id_c.rd == '0) id_c.rwe = 1'b0;
    end
  end

  // Hazard, flush and mult/div hold decisions for the current cycle.
  always_comb begin
`ifdef FORWARD_EN
    raw_c = ex_v && ex_c.rwd &&
            (hit(id_src_a, ex_v, ex_c.rwe, ex_c.rd) ||
             hit(id_src_b, ex_v, ex_c.rwe, ex_c.rd));
`else
    raw_c = hit(id_src_a, ex_v,  ex_c.rwe,  ex_c.rd)  ||
            hit(id_src_b, ex_v,  ex_c.rwe,  ex_c.rd)  ||
            hit(id_src_a, mem_v, mem_c.rwe, mem_c.rd) ||
            hit(id_src_b, mem_v, mem_c.rwe, mem_c.rd) ||
            hit(id_src_a, wb_v,  wb_c.rwe,  wb_c.rd)  ||
            hit(id_src_b, wb_v,  wb_c.rwe,  wb_c.rd);
`endif
    flush_c   = ex_v && bus.ex_taken &&
                (ex_c.bne || ex_c.blt || ex_c.bex || ex_c.jp || ex_c.jr);
    md_busy_c = ex_v && ex_c.md && !((state == S_WAIT) && bus.md_ready);
    ex_load_c = id_ok && !flush_c && !raw_c;
  end

  // Mult/div FSM next state: start leaves IDLE, ready in WAIT returns.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (ex_v && ex_c.md) state_nx = S_WAIT;
      S_WAIT:  if (bus.md_ready)    state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Stage registers and FSM state; EX holds and MEM takes a bubble while md busy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      ex_v     <= 1'b0;
      ex_c     <= '0;
      mem_v    <= 1'b0;
      mem_c    <= '0;
      wb_v     <= 1'b0;
      wb_c     <= '0;
`ifdef FORWARD_EN
      ex_src_a <= '0;
      ex_src_b <= '0;
`endif
    end else begin
      state <= state_nx;
      if (md_busy_c) begin
        mem_v <= 1'b0;
        mem_c <= '0;
      end else begin
        ex_v     <= ex_load_c;
        ex_c     <= ex_load_c ? id_c : '0;
`ifdef FORWARD_EN
        ex_src_a <= ex_load_c ? id_src_a : '0;
        ex_src_b <= ex_load_c ? id_src_b : '0;
`endif
        mem_v    <= ex_v;
        mem_c    <= '{dmwe: ex_c.dmwe, rwd: ex_c.rwd, rwe: ex_c.rwe,
                      sel: ex_c.sel, rd: ex_c.rd};
      end
      wb_v <= mem_v;
      wb_c <= '{rwe: mem_c.rwe, sel: mem_c.sel, rd: mem_c.rd};
    end
  end

  // Forwarding selects for the EX operands; MEM has priority over WB.
`ifdef FORWARD_EN
  assign bus.fwd_a = hit(ex_src_a, mem_v, mem_c.rwe, mem_c.rd) ? 2'b01 :
                     hit(ex_src_a, wb_v,  wb_c.rwe,  wb_c.rd)  ? 2'b10 : 2'b00;
  assign bus.fwd_b = hit(ex_src_b, mem_v, mem_c.rwe, mem_c.rd) ? 2'b01 :
                     hit(ex_src_b, wb_v,  wb_c.rwe,  wb_c.rd)  ? 2'b10 : 2'b00;
`else
  assign bus.fwd_a = 2'b00;
  assign bus.fwd_b = 2'b00;
`endif

  // Staged control outputs; flush takes priority over any stall.
  assign bus.stall         = !flush_c && (raw_c || md_busy_c);
  assign bus.flush         = flush_c;
  assign bus.md_start      = (state == S_IDLE) && ex_v && ex_c.md;
  assign bus.ex_alu_opcode = ex_c.alu_op;
  assign bus.ex_aluinb     = ex_c.aluinb;
  assign bus.ex_bne        = ex_c.bne;
  assign bus.ex_blt        = ex_c.blt;
  assign bus.ex_bex        = ex_c.bex;
  assign bus.ex_jp         = ex_c.jp;
  assign bus.ex_jr         = ex_c.jr;
  assign bus.mem_dmwe      = mem_c.dmwe;
  assign bus.mem_rwd       = mem_c.rwd;
  assign bus.wb_rwe        = wb_c.rwe;
  assign bus.wb_rd         = wb_c.rd;
  assign bus.wb_sel        = wb_c.sel;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed vector bench for pipe_ctrl; expectations follow the FORWARD_EN build option.
module tb_pipe_ctrl;
  localparam int unsigned RW = 5;
  localparam int EN_IMM = 32;  // ex_aluinb in {aluinb,bne,blt,bex,jp,jr}
  localparam int EN_BNE = 16;  // ex_bne

  logic clock;
  logic reset;

  pipe_ctrl_if #(.RW(RW)) bus();

  pipe_ctrl #(.RW(RW), .LINK_REG(31), .STATUS_REG(30)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic       vld;
    logic [4:0] op, alu, rd, rs, rt;
    logic       tk, rdy;
    logic       stall, flush, mds;
    logic [1:0] fa, fb;
    logic       wrwe;
    logic [4:0] wrd;
    logic [5:0] exen;
    logic [4:0] exalu;
  } vec_t;

  vec_t vq[$];
  int   n_cmp;
  int   n_bad;

  function automatic vec_t mk(input int vld, op, alu, rd, rs, rt, tk, rdy,
                              stall, flush, mds, fa, fb, wrwe, wrd, exen, exalu);
    vec_t v;
    v.vld = 1'(vld);   v.op = 5'(op);       v.alu = 5'(alu);
    v.rd = 5'(rd);     v.rs = 5'(rs);       v.rt = 5'(rt);
    v.tk = 1'(tk);     v.rdy = 1'(rdy);     v.stall = 1'(stall);
    v.flush = 1'(flush); v.mds = 1'(mds);   v.fa = 2'(fa);
    v.fb = 2'(fb);     v.wrwe = 1'(wrwe);   v.wrd = 5'(wrd);
    v.exen = 6'(exen); v.exalu = 5'(exalu);
    return v;
  endfunction

  // Idle ID slot with the given feedback inputs and expectations.
  function automatic vec_t mki(input int tk, rdy, stall, flush, mds, fa, fb,
                               wrwe, wrd, exen, exalu);
    return mk(0, 0, 0, 0, 0, 0, tk, rdy, stall, flush, mds, fa, fb, wrwe, wrd, exen, exalu);
  endfunction

  task automatic drive(input vec_t v);
    bus.id_valid  = v.vld;
    bus.id_opcode = v.op;
    bus.id_aluop  = v.alu;
    bus.id_rd     = v.rd;
    bus.id_rs     = v.rs;
    bus.id_rt     = v.rt;
    bus.ex_taken  = v.tk;
    bus.md_ready  = v.rdy;
  endtask

  task automatic check(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0h want %0h", nm, idx, act, exp);
    end
  endtask

  function automatic logic [31:0] all_out();
    return 32'({bus.stall, bus.flush, bus.ex_alu_opcode, bus.ex_aluinb, bus.ex_bne,
                bus.ex_blt, bus.ex_bex, bus.ex_jp, bus.ex_jr, bus.md_start, bus.fwd_a,
                bus.fwd_b, bus.mem_dmwe, bus.mem_rwd, bus.wb_rwe, bus.wb_rd, bus.wb_sel});
  endfunction

  initial begin
    vec_t idle_v;
    n_cmp = 0;
    n_bad = 0;
    idle_v = mki(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    drive(idle_v);

    // Reset held with random inputs: every output stays 0.
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      bus.id_valid  = 1'($urandom);
      bus.id_opcode = 5'($urandom);
      bus.id_aluop  = 5'($urandom);
      bus.id_rd     = 5'($urandom);
      bus.id_rs     = 5'($urandom);
      bus.id_rt     = 5'($urandom);
      bus.ex_taken  = 1'($urandom);
      bus.md_ready  = 1'($urandom);
      #1;
      check("reset_outputs", i, all_out(), 32'd0);
      check("reset_md_start", i, 32'(bus.md_start), 32'd0);
    end
    @(negedge clock);
    drive(idle_v);
    reset = 1'b1;

`ifdef FORWARD_EN
    // addi r1,r0,5 ; add r2,r1,r1 -> MEM forwarding on both operands, no stall
    vq.push_back(mk(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 0, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, EN_IMM, 0));
    vq.push_back(mki(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    vq.push_back(mki(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    vq.push_back(mki(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0));
    // lw r3 ; add r4,r3,r0 -> one stall, EX bubble, then WB forwarding
    vq.push_back(mk(1, 8, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 0, 4, 3, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, EN_IMM, 0));
    vq.push_back(mk(1, 0, 0, 4, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mki(0, 0, 0, 0, 0, 2, 0, 1, 3, 0, 0));
    vq.push_back(mki(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mki(0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0));
`else
    // addi r1,r0,5 ; add r2,r1,r0 -> three stall cycles, no forwarding
    vq.push_back(mk(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 0, 2, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, EN_IMM, 0));
    vq.push_back(mk(1, 0, 0, 2, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 0, 2, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0));
    vq.push_back(mk(1, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mki(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mki(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mki(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0));
    // lw r3 ; add r4,r3,r0 -> stalls until the load leaves WB
    vq.push_back(mk(1, 8, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 0, 4, 3, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, EN_IMM, 0));
    vq.push_back(mk(1, 0, 0, 4, 3, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 0, 4, 3, 0, 0, 0, 1, 0, 0, 0, 0, 1, 3, 0, 0));
    vq.push_back(mk(1, 0, 0, 4, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mki(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mki(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mki(0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0));
`endif
    // taken bne flushes; the wrong-path addi r6 never writes back
    vq.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 5, 0, 6, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, EN_BNE, 1));
    vq.push_back(mki(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mki(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mki(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // not-taken bne, then ex_taken with a non-control op in EX: no flush
    vq.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 5, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, EN_BNE, 1));
    vq.push_back(mki(1, 0, 0, 0, 0, 0, 0, 0, 0, EN_IMM, 0));
    vq.push_back(mki(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mki(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0));
    // mul r5: ready pulse while IDLE ignored, start once, stall until ready
    vq.push_back(mk(1, 0, 6, 5, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mki(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 6));
    vq.push_back(mki(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 6));
    vq.push_back(mki(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 6));
    vq.push_back(mki(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 6));
    vq.push_back(mki(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 6));
    vq.push_back(mki(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mki(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0));
    // addi r0 never writes; an unknown opcode becomes a bubble
    vq.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 15, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, EN_IMM, 0));
    vq.push_back(mki(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mki(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mki(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    foreach (vq[i]) begin
      @(negedge clock);
      drive(vq[i]);
      #1;
      check("stall",    i, 32'(bus.stall),         32'(vq[i].stall));
      check("flush",    i, 32'(bus.flush),         32'(vq[i].flush));
      check("md_start", i, 32'(bus.md_start),      32'(vq[i].mds));
      check("fwd_a",    i, 32'(bus.fwd_a),         32'(vq[i].fa));
      check("fwd_b",    i, 32'(bus.fwd_b),         32'(vq[i].fb));
      check("wb_rwe",   i, 32'(bus.wb_rwe),        32'(vq[i].wrwe));
      check("wb_rd",    i, 32'(bus.wb_rd),         32'(vq[i].wrd));
      check("ex_en",    i, 32'({bus.ex_aluinb, bus.ex_bne, bus.ex_blt, bus.ex_bex,
                                bus.ex_jp, bus.ex_jr}), 32'(vq[i].exen));
      check("ex_alu",   i, 32'(bus.ex_alu_opcode), 32'(vq[i].exalu));
    end

    // Reset asserted while mul waits: outputs clear at once, FSM back to IDLE.
    @(negedge clock);
    drive(mk(1, 0, 6, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clock);
    drive(idle_v);
    #1;
    check("mr_start", 0, 32'(bus.md_start), 32'd1);
    @(negedge clock);
    #1;
    check("mr_wait_stall", 0, 32'(bus.stall), 32'd1);
    check("mr_wait_start", 0, 32'(bus.md_start), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    check("mr_async_clear", 0, all_out(), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    bus.md_ready = 1'b1;
    #1;
    check("mr_idle_stall", 0, 32'(bus.stall), 32'd0);
    check("mr_idle_start", 0, 32'(bus.md_start), 32'd0);
    bus.md_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      #1;
      check("mr_no_wb", i, 32'(bus.wb_rwe), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Parametrised pipelined successor to the single-cycle decoder. It decodes the ID-stage opcode/aluOp and carries the control word through ID/EX/MEM/WB stage registers. It detects RAW and load-use hazards, drives forwarding selects, flushes on taken control transfers, and runs a mult/div start/ready handshake FSM. It sits beside the 5-stage datapath; all datapath muxes and write enables come from its staged outputs.

Parameters:
RW, 5, register-address width (register file has 2^RW entries; r0 hard zero)
LINK_REG, 31, destination of jal
STATUS_REG, 30, destination of setx, source of bex

Ports:
clock  in  1  pipeline clock
reset  in  1  asynchronous, active-low; 0 clears all state
id_valid  in  1  ID holds a real instruction
id_opcode  in  5  instruction [31:27]
id_aluop  in  5  R-type ALU op field
id_rd, id_rs, id_rt  in  RW each  register fields
ex_taken  in  1  datapath: EX branch condition true / EX jump
md_ready  in  1  mult/div result valid
stall  out  1  hold PC and IF/ID
flush  out  1  invalidate IF/ID
ex_alu_opcode  out  5  ALU op for EX
ex_aluinb, ex_bne, ex_blt, ex_bex, ex_jp, ex_jr  out  1 each  EX controls
md_start  out  1  one-cycle mult/div start
fwd_a, fwd_b  out  2 each  00 regfile, 01 MEM result, 10 WB result
mem_dmwe, mem_rwd  out  1 each  store enable / load select
wb_rwe  out  1  regfile write enable
wb_rd  out  RW  write address
wb_sel  out  2  00 ALU, 01 memory, 10 PC+1, 11 setx target

Behaviour:
- Decode: add 00000 (R-type, ALU op = aluOp), j 00001, bne 00010, jal 00011, jr 00100, addi 00101, blt 00110, sw 00111, lw 01000, setx 10101, bex 10110. Any other opcode becomes a bubble (all enables 0).
- ALU op mapping: bne/blt/bex give 00001; addi/lw/sw give 00000.
- R-type aluOp 00110 (mul) or 00111 (div) marks the instruction md.
- Sources:
  - R-type: rs, rt; addi/lw: rs; sw: rs, rd; bne/blt: rd, rs; jr: rd; bex: STATUS_REG.
- Destinations:
  - R-type/addi/lw: rd; jal: LINK_REG; setx: STATUS_REG.
  - Destination r0 forces rwe=0.
- Stage registers (ex/mem/wb) each hold valid plus the control word and rd. Reset value is 0 for every output and stage register.
- Hazard compares use only valid stages with rwe=1 and source ≠ 0.
- Load-use: EX is a valid lw and ID reads its rd. Then stall=1 for one cycle and a bubble enters EX.
- Forwarding: MEM match gives 01. Otherwise WB match gives 10. MEM wins when both match.
- Flush: ex_taken=1 with EX a valid bne/blt/bex/j/jal/jr sets flush=1 in that cycle.
  - Next cycle EX holds a bubble.
  - Flush overrides stall.
  - Two cycles of penalty.
- md FSM, IDLE→WAIT:
  - In IDLE, a valid md in EX pulses md_start for exactly one cycle and moves to WAIT.
  - In WAIT: stall=1, EX held, bubble into MEM, md_start=0. md_ready is ignored while IDLE.
  - md_ready=1 in WAIT: EX advances that edge and the FSM returns to IDLE.
  - A flush never hits an md in EX, because md is not a control transfer.
- Reset asserted mid-operation: FSM returns to IDLE, all valids clear, outputs go to 0 asynchronously.

Optional Feature:
FORWARD_EN.
- Defined: forwarding as above; only load-use and md stall.
- Undefined:
  - fwd_a/fwd_b are tied to 00.
  - Any ID source matching a valid rwe destination in EX, MEM or WB stalls until the writer leaves WB.
  - A bubble is inserted into EX each stalled cycle.

Test Plan:
- Reset: hold reset=0 3 cycles with random inputs -> all outputs 0, md_start never 1.
- FORWARD_EN on: addi r1,r0,5 then add r2,r1,r1 -> fwd_a=fwd_b=01 on the add's EX cycle; no stall.
- Load-use: lw r3 then add r4,r3,r0 -> stall=1 exactly one cycle, EX bubble, then fwd_a=10.
- Branch: bne in EX with ex_taken=1 -> flush=1 that cycle. Next cycle all EX enables 0, and the following instruction never reaches wb_rwe.
- Mult/div: mul r5 in EX, md_ready after 4 cycles:
  - md_start high 1 cycle; stall high until md_ready; wb_rwe=1 with wb_rd=5 two cycles later.
  - md_ready pulsed while IDLE is ignored.
- FORWARD_EN off: addi r1 then add r2,r1,r0 -> stall 3 cycles, fwd_a stays 00.
